// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: single-master I2C sequencer for START/RESTART/STOP and 9-bit byte transfers
//   clk, reset     : system clock, asynchronous active-high reset
//   cmd, din       : command code and write byte (RD uses din[0] as the master ACK bit)
//   wr_i2c         : command strobe, accepted only while ready
//   dvsr           : quarter-bit period minus one
//   ready          : engine idle or holding the bus, can take a command
//   ack, dout      : slave ACK of the last WR, byte captured by the last RD
//   done_tick      : one-cycle pulse when a WR/RD byte completes
//   scl, sda       : open-drain bus lines, driven 0 or released
module i2c_bit_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din,
    input  logic [2:0]  cmd,
    input  logic [15:0] dvsr,
    input  logic        wr_i2c,
    output logic        ready,
    output logic        ack,
    output logic [7:0]  dout,
    output logic        done_tick,
    output tri          scl,
    inout  tri          sda
);
    localparam logic [2:0] CMD_START = 3'b000, CMD_WR = 3'b001, CMD_RD = 3'b010,
                           CMD_STOP = 3'b011, CMD_RESTART = 3'b100;
    typedef enum logic [3:0] {
        IDLE, START1, START2, HOLD, DATA1, DATA2, DATA3, DATA4, DATA_END,
        RESTART1, RESTART2, STOP1, STOP2
    } state_t;
    state_t      state, state_n;
    logic [15:0] c, c_n;
    logic        h, h_n, rd, rd_n, ack_n, done_n, scl_reg, sda_reg, scl_n, sda_n, qend, go, sda_in;
    logic [3:0]  bitc, bitc_n;
    logic [8:0]  tx, tx_n, rx, rx_n;
    logic [7:0]  dout_n;
    assign sda_in = sda;
    assign scl = scl_reg ? 1'bz : 1'b0;
    assign sda = sda_reg ? 1'bz : 1'b0;
    // h marks the second quarter of the two-quarter phases
    always_comb begin
        qend = c == dvsr;
        ready = state == IDLE || state == HOLD;
        go = wr_i2c && ready;
        state_n = state;
        c_n = (ready || qend) ? 16'd0 : c + 16'd1;
        h_n = h;
        bitc_n = bitc;
        tx_n = tx;
        rx_n = rx;
        rd_n = rd;
        ack_n = ack;
        dout_n = dout;
        done_n = 1'b0;
        case (state)
            IDLE:     if (go && cmd == CMD_START) state_n = START1;
            START1:   if (qend) begin h_n = ~h; if (h) state_n = START2; end
            START2:   if (qend) state_n = HOLD;
            HOLD: if (go) case (cmd)
                CMD_WR:                 begin tx_n = {din, 1'b1}; bitc_n = 4'd0; rd_n = 1'b0; state_n = DATA1; end
                CMD_RD:                 begin tx_n = {8'hFF, din[0]}; bitc_n = 4'd0; rd_n = 1'b1; state_n = DATA1; end
                CMD_STOP:               state_n = STOP1;
                CMD_START, CMD_RESTART: state_n = RESTART1;
                default: ;
            endcase
            DATA1:    if (qend) state_n = DATA2;
            DATA2:    if (qend) begin rx_n = {rx[7:0], sda_in}; state_n = DATA3; end
            DATA3:    if (qend) state_n = DATA4;
            DATA4: if (qend) begin
                tx_n = {tx[7:0], 1'b0};
                state_n = (bitc == 4'd8) ? DATA_END : DATA1;
                bitc_n = (bitc == 4'd8) ? bitc : bitc + 4'd1;
            end
            DATA_END: if (qend) begin
                done_n = 1'b1;
                ack_n = rd ? ack : rx[0];
                dout_n = rd ? rx[8:1] : dout;
                state_n = HOLD;
            end
            RESTART1: if (qend) state_n = RESTART2;
            RESTART2: if (qend) begin h_n = ~h; if (h) state_n = START1; end
            STOP1:    if (qend) begin h_n = ~h; if (h) state_n = STOP2; end
            STOP2:    if (qend) begin h_n = ~h; if (h) state_n = IDLE; end
            default:  state_n = IDLE;
        endcase
    end
    // line levels follow the next state so the pins change together with it
    always_comb begin
        scl_n = !(state_n inside {START2, HOLD, DATA1, DATA4, DATA_END, RESTART1});
        sda_n = (state_n inside {DATA1, DATA2, DATA3, DATA4}) ? tx_n[8] :
                (state_n inside {IDLE, RESTART1, RESTART2, STOP2});
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            c <= 16'd0;
            h <= 1'b0;
            bitc <= 4'd0;
            tx <= 9'd0;
            rx <= 9'd0;
            rd <= 1'b0;
            ack <= 1'b0;
            dout <= 8'd0;
            done_tick <= 1'b0;
            scl_reg <= 1'b1;
            sda_reg <= 1'b1;
        end else begin
            state <= state_n;
            c <= c_n;
            h <= h_n;
            bitc <= bitc_n;
            tx <= tx_n;
            rx <= rx_n;
            rd <= rd_n;
            ack <= ack_n;
            dout <= dout_n;
            done_tick <= done_n;
            scl_reg <= scl_n;
            sda_reg <= sda_n;
        end
    end
endmodule
